// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the main-memory read/write arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    // One memory command as latched at grant time
    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_rwport.sv
// Single read/write port of main memory; master drives the command,
// memory returns registered read data one cycle after val.
interface mem_rwport;
    import mem_arb_pkg::*;

    logic              val;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdy;

    modport master (output val, output wen, output addr, output wdata,
                    input rdata, input rdy);
    modport slave  (input val, input wen, input addr, input wdata,
                    output rdata, output rdy);
endinterface

// File: rtl/mem_rw_arbiter_rr_picker.sv
// Combinational round-robin picker: search starts one past the last winner.
// With MEM_ARB_FIXED_PRIO_EN defined, requester 0 is masked out of the
// rotation and instead wins outright whenever it requests.
module rr_picker
#(
    parameter int NREQ = 3
)
(
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    any_req_o
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] rr_mask;
    logic [NREQ-1:0] elig;
    logic [PW-1:0]   idx;
    logic            found;

    // Rotating search over the eligible requesters, then fixed-priority override
    always_comb begin
        rr_mask = '1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        rr_mask[0] = 1'b0;
`endif
        elig  = req_i & rr_mask;
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = PW'((32'(ptr_i) + k) % NREQ);
            if (!found && elig[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (req_i[0]) begin
            gnt_o    = '0;
            gnt_o[0] = 1'b1;
        end
`endif
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/mem_rw_arbiter.sv
// Main-memory read/write arbiter: waits out the post-reset memory wipe,
// then grants one requester at a time and sequences the access through
// the memory's one-cycle registered read (ISSUE -> WAIT -> DONE).
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (requester 0 fixed priority).
module mem_rw_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int CLEAR_CYCLES = 256
)
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_val_i,
    input  logic [NREQ-1:0]          req_wen_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*DATA_W-1:0]   req_wdata_i,
    output logic [NREQ-1:0]          req_rdy_o,
    output logic [DATA_W-1:0]        req_rdata_o,
    output logic                     init_done_o,
    mem_rwport.master                mem
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

    arb_state_e      state;
    logic [CW-1:0]   clr_cnt;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] gnt;
    logic            any_req;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_q;
    mem_cmd_t        sel_cmd;
    mem_cmd_t        cmd_q;
    logic            mem_val_q;
    logic            unused_rdy;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req_i     (req_val_i),
        .ptr_i     (ptr),
        .gnt_o     (gnt),
        .any_req_o (any_req)
    );

    // One-hot grant to requester index
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    // Mux the winning requester's command fields
    always_comb begin
        sel_cmd.wen   = req_wen_i[gnt_idx];
        sel_cmd.addr  = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
        sel_cmd.wdata = req_wdata_i[gnt_idx*DATA_W +: DATA_W];
    end

    // Access sequencer: clear window, grant, issue, wait for read, complete
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_INIT;
            clr_cnt     <= '0;
            init_done_o <= 1'b0;
            ptr         <= PW'(NREQ - 1);
            gnt_q       <= '0;
            cmd_q       <= '0;
            mem_val_q   <= 1'b0;
            req_rdy_o   <= '0;
            req_rdata_o <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (clr_cnt == CLR_LAST) begin
                        state       <= ST_IDLE;
                        init_done_o <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (any_req) begin
                        cmd_q     <= sel_cmd;
                        gnt_q     <= gnt;
                        mem_val_q <= 1'b1;
                        state     <= ST_ISSUE;
`ifdef MEM_ARB_FIXED_PRIO_EN
                        // requester 0 sits outside the rotation
                        if (!gnt[0]) ptr <= gnt_idx;
`else
                        ptr <= gnt_idx;
`endif
                    end
                end
                ST_ISSUE: begin
                    mem_val_q <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!cmd_q.wen) req_rdata_o <= mem.rdata;
                    req_rdy_o <= gnt_q;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    req_rdy_o <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign mem.val    = mem_val_q;
    assign mem.wen    = cmd_q.wen;
    assign mem.addr   = cmd_q.addr;
    assign mem.wdata  = cmd_q.wdata;
    assign unused_rdy = mem.rdy;

endmodule
